// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencer: advances IP by 4, stalls on control-flow ops, then redirects or falls through.
// Latency: IP is registered; control-flow ops cost RESOLVE_DELAY bubble cycles before the new IP appears.
// Backpressure: HOLD freezes all state. Optional PC_ALIGN_CHECK_EN macro traps on misaligned taken targets.
module fetch_pc_unit #(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR  = '0,
    parameter int              RESOLVE_DELAY = 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            HOLD,
    input  logic [6:0]      OP,
    input  logic            B_TAKEN,
    input  logic [XLEN-1:0] TARGET_OFFSET,
    input  logic [XLEN-1:0] RS1_DATA,
    input  logic [11:0]     IMM_I,
    output logic [XLEN-1:0] IP,
    output logic [XLEN-1:0] PC_DEF,
    output logic            FETCH_VALID,
    output logic            REDIRECT,
    output logic            TRAP
);

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
`ifdef PC_ALIGN_CHECK_EN
    localparam logic [1:0] ST_TRAPPED = 2'd2;
`endif

    localparam int              CNT_W     = 4;
    localparam logic [XLEN-1:0] FOUR      = XLEN'(4);
    localparam logic [XLEN-1:0] BIT0_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    // Captured control-flow kind, one-hot: [2] branch, [1] jal, [0] jalr.
    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [XLEN-1:0]  ip_q,      ip_d;
    logic [XLEN-1:0]  cf_pc_q,   cf_pc_d;
    logic [2:0]       cf_kind_q, cf_kind_d;
    logic             redirect_q, redirect_d;

    logic             is_branch, is_jal, is_jalr, is_cf;
    logic [XLEN-1:0]  imm_sext;
    logic [XLEN-1:0]  pc_rel_tgt;
    logic [XLEN-1:0]  jalr_tgt;
    logic [XLEN-1:0]  target;
    logic             taken;

    // Opcode decode and target arithmetic; all sums wrap modulo 2^XLEN.
    always_comb begin
        is_branch  = (OP == OPC_BRANCH);
        is_jal     = (OP == OPC_JAL);
        is_jalr    = (OP == OPC_JALR);
        is_cf      = is_branch | is_jal | is_jalr;
        imm_sext   = {{(XLEN-12){IMM_I[11]}}, IMM_I};
        pc_rel_tgt = cf_pc_q + TARGET_OFFSET;
        jalr_tgt   = (RS1_DATA + imm_sext) & BIT0_MASK;
        target     = cf_kind_q[0] ? jalr_tgt : pc_rel_tgt;
        taken      = cf_kind_q[1] | cf_kind_q[0] | (cf_kind_q[2] & B_TAKEN);
    end

`ifdef PC_ALIGN_CHECK_EN
    logic trap_q, trap_d;
`endif

    // Next-state logic: sequential advance in RUN, bubble countdown and resolution in WAIT.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ip_d       = ip_q;
        cf_pc_d    = cf_pc_q;
        cf_kind_d  = cf_kind_q;
        redirect_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        trap_d     = trap_q;
`endif
        if (!HOLD) begin
            case (state_q)
                ST_RUN: begin
                    if (is_cf) begin
                        cf_pc_d   = ip_q;
                        cf_kind_d = {is_branch, is_jal, is_jalr};
                        cnt_d     = CNT_W'(RESOLVE_DELAY - 1);
                        state_d   = ST_WAIT;
                    end else begin
                        ip_d = ip_q + FOUR;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        // Resolve cycle: operands are sampled from this cycle's inputs.
                        state_d = ST_RUN;
                        if (taken) begin
`ifdef PC_ALIGN_CHECK_EN
                            if (target[1:0] != 2'b00) begin
                                ip_d    = cf_pc_q;
                                trap_d  = 1'b1;
                                state_d = ST_TRAPPED;
                            end else begin
                                ip_d       = target;
                                redirect_d = 1'b1;
                            end
`else
                            ip_d       = target;
                            redirect_d = 1'b1;
`endif
                        end else begin
                            ip_d = cf_pc_q + FOUR;
                        end
                    end
                end
`ifdef PC_ALIGN_CHECK_EN
                ST_TRAPPED: begin
                    // Frozen until reset.
                    state_d = ST_TRAPPED;
                end
`endif
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            ip_q       <= RESET_VECTOR;
            cf_pc_q    <= '0;
            cf_kind_q  <= '0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ip_q       <= ip_d;
            cf_pc_q    <= cf_pc_d;
            cf_kind_q  <= cf_kind_d;
            redirect_q <= redirect_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Sticky misalignment trap flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end
    assign TRAP = trap_q;
`else
    assign TRAP = 1'b0;
`endif

    assign IP          = ip_q;
    assign PC_DEF      = ip_q + FOUR;
    assign FETCH_VALID = (state_q == ST_RUN);
    assign REDIRECT    = redirect_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: two instances (resolve delay 1 and 3), each with its own stimulus stream.
// Directed scenarios followed by a randomized run, every cycle compared against a reference model.
// Summary line reports total and failed comparisons.
module tb_fetch_pc_unit;

    localparam logic [6:0]  JAL  = 7'b1101111;
    localparam logic [6:0]  JALR = 7'b1100111;
    localparam logic [6:0]  BR   = 7'b1100011;
    localparam logic [6:0]  SEQ  = 7'b0010011;
    localparam logic [31:0] RV   = 32'h100;

    typedef struct packed {
        logic        rst;
        logic        hold;
        logic [6:0]  op;
        logic        bt;
        logic [31:0] off;
        logic [31:0] rs1;
        logic [11:0] imm;
    } stim_t;

    // Reference model: "busy" means a control-flow op is pending, "waited" counts bubbles already spent.
    typedef struct {
        logic [31:0] ip;
        bit          busy;
        int          waited;
        logic [31:0] cf_pc;
        logic [6:0]  cf_op;
        bit          redir;
        bit          trap;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    stim_t s1, s3;
    mdl_t  m1, m3;
    int    tests = 0;
    int    fails = 0;

    logic [31:0] ip1, pcd1, ip3, pcd3;
    logic        fv1, rd1, tr1, fv3, rd3, tr3;

    fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .RESOLVE_DELAY(1)) dut1 (
        .CLK(clk), .RESET(s1.rst), .HOLD(s1.hold), .OP(s1.op), .B_TAKEN(s1.bt),
        .TARGET_OFFSET(s1.off), .RS1_DATA(s1.rs1), .IMM_I(s1.imm),
        .IP(ip1), .PC_DEF(pcd1), .FETCH_VALID(fv1), .REDIRECT(rd1), .TRAP(tr1)
    );

    fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .RESOLVE_DELAY(3)) dut3 (
        .CLK(clk), .RESET(s3.rst), .HOLD(s3.hold), .OP(s3.op), .B_TAKEN(s3.bt),
        .TARGET_OFFSET(s3.off), .RS1_DATA(s3.rs1), .IMM_I(s3.imm),
        .IP(ip3), .PC_DEF(pcd3), .FETCH_VALID(fv3), .REDIRECT(rd3), .TRAP(tr3)
    );

    function automatic mdl_t mstep(input mdl_t m, input stim_t s, input int delay);
        mdl_t        n;
        bit          tk;
        logic [31:0] tgt;
        n = m;
        n.redir = 1'b0;
        if (s.rst) begin
            n.ip = RV; n.busy = 1'b0; n.waited = 0; n.trap = 1'b0;
            return n;
        end
        if (s.hold || m.trap) return n;
        if (!m.busy) begin
            if (s.op inside {JAL, JALR, BR}) begin
                n.busy = 1'b1; n.waited = 0; n.cf_pc = m.ip; n.cf_op = s.op;
            end else begin
                n.ip = m.ip + 32'd4;
            end
        end else if (m.waited + 1 < delay) begin
            n.waited = m.waited + 1;
        end else begin
            n.busy = 1'b0;
            tk = (m.cf_op != BR) || s.bt;
            if (m.cf_op == JALR) tgt = (s.rs1 + {{20{s.imm[11]}}, s.imm}) & ~32'd1;
            else                 tgt = m.cf_pc + s.off;
            if (!tk) begin
                n.ip = m.cf_pc + 32'd4;
            end else begin
`ifdef PC_ALIGN_CHECK_EN
                if (tgt[1:0] != 2'b00) n.trap = 1'b1;
                else begin n.ip = tgt; n.redir = 1'b1; end
`else
                n.ip = tgt; n.redir = 1'b1;
`endif
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_models();
        chk("m1_ip",  64'(ip1),  64'(m1.ip));
        chk("m1_pcd", 64'(pcd1), 64'(m1.ip + 32'd4));
        chk("m1_fv",  64'(fv1),  64'(!m1.busy && !m1.trap));
        chk("m1_rd",  64'(rd1),  64'(m1.redir));
        chk("m1_tr",  64'(tr1),  64'(m1.trap));
        chk("m3_ip",  64'(ip3),  64'(m3.ip));
        chk("m3_pcd", 64'(pcd3), 64'(m3.ip + 32'd4));
        chk("m3_fv",  64'(fv3),  64'(!m3.busy && !m3.trap));
        chk("m3_rd",  64'(rd3),  64'(m3.redir));
        chk("m3_tr",  64'(tr3),  64'(m3.trap));
    endtask

    task automatic step(input stim_t a, input stim_t b);
        s1 = a;
        s3 = b;
        @(posedge clk);
        m1 = mstep(m1, a, 1);
        m3 = mstep(m3, b, 3);
        #1;
        cmp_models();
    endtask

    function automatic stim_t mk(input logic [6:0] op, input logic [31:0] off);
        stim_t s;
        s = '0;
        s.op = op;
        s.off = off;
        return s;
    endfunction

    task automatic reset_both();
        stim_t r;
        r = mk(SEQ, 32'd0);
        r.rst = 1'b1;
        step(r, r);
        step(r, r);
    endtask

    initial begin
        stim_t idle, a, r;
        idle = mk(SEQ, 32'd0);
        m1 = '{ip: 32'd0, busy: 1'b0, waited: 0, cf_pc: 32'd0, cf_op: 7'd0, redir: 1'b0, trap: 1'b0};
        m3 = m1;
        s1 = idle;
        s3 = idle;

        // Reset and sequential run
        reset_both();
        chk("rst_ip",  64'(ip1),  64'h100);
        chk("rst_pcd", 64'(pcd1), 64'h104);
        chk("rst_fv",  64'(fv1),  64'd1);
        chk("rst_rd",  64'(rd3),  64'd0);
        chk("rst_tr",  64'(tr3),  64'd0);
        step(idle, idle);
        chk("seq_ip1", 64'(ip1), 64'h104);
        step(idle, idle);
        chk("seq_ip2", 64'(ip3), 64'h108);
        chk("seq_pcd", 64'(pcd3), 64'h10C);

        // Taken branch on the delay-1 instance, starting from IP 0x10
        reset_both();
        step(mk(JAL, 32'hFFFF_FF10), idle);
        step(mk(SEQ, 32'hFFFF_FF10), idle);
        chk("jal_ip",  64'(ip1), 64'h10);
        step(mk(BR, 32'd0), idle);
        chk("br_bub_ip", 64'(ip1), 64'h10);
        chk("br_bub_fv", 64'(fv1), 64'd0);
        a = mk(SEQ, 32'h20);
        a.bt = 1'b1;
        step(a, idle);
        chk("br_tk_ip", 64'(ip1), 64'h30);
        chk("br_tk_rd", 64'(rd1), 64'd1);
        step(idle, idle);
        chk("br_rd_pulse", 64'(rd1), 64'd0);

        // Not-taken branch on the delay-3 instance at IP 0x40
        reset_both();
        for (int i = 0; i < 4; i++) step(idle, mk(i == 0 ? JAL : SEQ, 32'hFFFF_FF40));
        chk("jal3_ip", 64'(ip3), 64'h40);
        step(idle, mk(BR, 32'h0));
        for (int i = 0; i < 2; i++) begin
            step(idle, mk(SEQ, 32'h0));
            chk("nt_bub_ip", 64'(ip3), 64'h40);
            chk("nt_bub_fv", 64'(fv3), 64'd0);
        end
        step(idle, mk(SEQ, 32'h0));
        chk("nt_ip", 64'(ip3), 64'h44);
        chk("nt_rd", 64'(rd3), 64'd0);

        // JALR with bit-0 clear and wrap-around
        reset_both();
        a = mk(JALR, 32'd0);
        a.rs1 = 32'hFFFF_FFFC;
        a.imm = 12'h009;
        step(a, idle);
        a.op = SEQ;
        step(a, idle);
        chk("jalr_ip", 64'(ip1), 64'h4);
        chk("jalr_rd", 64'(rd1), 64'd1);

        // HOLD across the resolve cycle of JAL at 0x80 with offset -8
        reset_both();
        step(mk(JAL, 32'hFFFF_FF80), idle);
        step(mk(SEQ, 32'hFFFF_FF80), idle);
        step(mk(JAL, 32'hFFFF_FFF8), idle);
        a = mk(SEQ, 32'hFFFF_FFF8);
        a.hold = 1'b1;
        step(a, idle);
        chk("hold_ip1", 64'(ip1), 64'h80);
        step(a, idle);
        chk("hold_ip2", 64'(ip1), 64'h80);
        chk("hold_rd",  64'(rd1), 64'd0);
        a.hold = 1'b0;
        step(a, idle);
        chk("hold_rel_ip",  64'(ip1),  64'h78);
        chk("hold_rel_pcd", 64'(pcd1), 64'h7C);
        a.hold = 1'b1;
        step(a, idle);
        chk("hold_no_stretch", 64'(rd1), 64'd0);

        // Reset in the middle of WAIT on the delay-3 instance
        reset_both();
        step(idle, mk(JAL, 32'h40));
        step(idle, mk(SEQ, 32'h40));
        r = mk(SEQ, 32'h40);
        r.rst = 1'b1;
        step(idle, r);
        chk("rwait_ip", 64'(ip3), 64'h100);
        chk("rwait_fv", 64'(fv3), 64'd1);
        step(idle, mk(SEQ, 32'h40));
        chk("rwait_ip2", 64'(ip3), 64'h104);
        chk("rwait_rd",  64'(rd3), 64'd0);

`ifdef PC_ALIGN_CHECK_EN
        // Misaligned JAL target at 0x20 traps and freezes until reset
        reset_both();
        step(mk(JAL, 32'hFFFF_FF20), idle);
        step(mk(SEQ, 32'hFFFF_FF20), idle);
        step(mk(JAL, 32'h6), idle);
        step(mk(SEQ, 32'h6), idle);
        chk("trap_tr", 64'(tr1), 64'd1);
        chk("trap_ip", 64'(ip1), 64'h20);
        chk("trap_fv", 64'(fv1), 64'd0);
        chk("trap_rd", 64'(rd1), 64'd0);
        step(idle, idle);
        step(idle, idle);
        chk("trap_frozen_ip", 64'(ip1), 64'h20);
        chk("trap_sticky",    64'(tr1), 64'd1);
        reset_both();
        chk("trap_clr", 64'(tr1), 64'd0);
`else
        // Misaligned JAL target is loaded unchecked
        reset_both();
        step(mk(JAL, 32'h6), idle);
        step(mk(SEQ, 32'h6), idle);
        chk("misal_ip", 64'(ip1), 64'h106);
        chk("misal_tr", 64'(tr1), 64'd0);
`endif

        // Randomized run, compared cycle by cycle against the model
        for (int i = 0; i < 2000; i++) begin
            stim_t rs[2];
            for (int k = 0; k < 2; k++) begin
                int sel;
                rs[k] = '0;
                rs[k].rst  = ($urandom_range(0, 63) == 0);
                rs[k].hold = ($urandom_range(0, 5) == 0);
                sel = int'($urandom_range(0, 5));
                case (sel)
                    0:       rs[k].op = JAL;
                    1:       rs[k].op = JALR;
                    2:       rs[k].op = BR;
                    default: rs[k].op = 7'($urandom);
                endcase
                rs[k].bt  = 1'($urandom);
                if ($urandom_range(0, 1) == 0) rs[k].off = {22'($urandom_range(0, 1) ? 22'h3FFFFF : 22'h0), 8'($urandom), 2'b00};
                else                           rs[k].off = $urandom;
                rs[k].rs1 = $urandom;
                rs[k].imm = 12'($urandom);
            end
            step(rs[0], rs[1]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
